serial_parity_rx: RTL and testbench
===================================

SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 SHALL have parameter ODD_PARITY, default 0; 0 = even parity, 1 = odd parity.
REQ-002 SHALL have parameter LSB_FIRST, default 1; 1 = data bit 0 received first, 0 = bit 7 first.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rx_valid  input  1  qualifies rx_bit for one cycle (one line bit per strobe).
REQ-006 SHALL have port rx_bit  input  1  serial line value; idle level 1.
REQ-007 SHALL have port out_ready  input  1  downstream accepts the held frame.
REQ-008 SHALL have port out_valid  output  1  held frame available.
REQ-009 SHALL have port out_data  output  8  received data byte.
REQ-010 SHALL have port out_perr  output  1  parity error flag for out_data.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-013 SHALL implement states IDLE, DATA, PARITY; state advances only on cycles with rx_valid=1.
REQ-014 In IDLE, rx_valid with rx_bit=0 (start bit) SHALL move to DATA with the bit counter cleared; rx_valid with rx_bit=1 SHALL be ignored.
REQ-015 In DATA, each rx_valid SHALL shift rx_bit into the shift register in LSB_FIRST order and increment the counter; the 8th data bit SHALL move to PARITY.
REQ-016 In PARITY, rx_valid SHALL capture the parity bit and return to IDLE; no stop bit is required.
REQ-017 perr SHALL be XOR-reduction of the 8 data bits and the parity bit, XORed with ODD_PARITY; 1 = error.
REQ-018 On parity capture with out_valid=0, or out_valid=1 and out_ready=1 in the same cycle, out_data/out_perr SHALL load and out_valid SHALL be 1 on the following cycle (latency 1 cycle after the parity-bit edge).
REQ-019 On parity capture with out_valid=1 and out_ready=0, the new frame SHALL be dropped, the held frame SHALL be unchanged, and overrun SHALL pulse high for exactly one cycle.
REQ-020 out_valid SHALL remain high, and out_data/out_perr SHALL remain stable, until a cycle with out_valid=1 and out_ready=1; out_valid SHALL then clear unless REQ-018 reloads it in the same cycle.
REQ-021 Cycles with rx_valid=0 SHALL hold state, counter and shift register unchanged, with no timeout.
REQ-022 Reception SHALL proceed independently of the output handshake; a new frame may be received while a frame is held.

Reset
REQ-023 With rst_n=0 at a clock edge, state SHALL become IDLE, counter 0, shift register 0x00, out_valid 0, out_data 0x00, out_perr 0, overrun 0, busy 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; no out_valid or overrun SHALL result.
REQ-025 rst_n SHALL override all other inputs in the same cycle.

Configuration
REQ-026 With macro SPRX_ERR_CNT_EN defined, the block SHALL add output err_cnt (8 bits): reset 0, +1 whenever a frame with perr=1 is loaded per REQ-018, saturating at 255, and not incremented for dropped frames.
REQ-027 Without SPRX_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Even, LSB_FIRST: start 0, bits 1,0,1,0,0,1,0,1, parity 0, out_ready=1 -> out_valid one cycle after the parity edge, out_data=0xA5, out_perr=0.
REQ-029 Even: data 0x01, parity 0 -> out_data=0x01, out_perr=1; with SPRX_ERR_CNT_EN, err_cnt goes 0 -> 1.
REQ-030 ODD_PARITY=1: data 0xFF, parity 1 -> out_perr=0; same frame with parity 0 -> out_perr=1.
REQ-031 out_ready=0, two complete frames 0x3C then 0xC3 -> out_data stays 0x3C, overrun pulses once on the second parity edge; raising out_ready drops out_valid.
REQ-032 rst_n=0 after 4 data bits, then a full frame 0x5A -> only 0x5A is delivered; rx_bit=1 strobes in IDLE -> busy stays 0.

Source files
------------

// File: rtl/serial_parity_rx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_parity_rx
//  Purpose  : Receives a strobed serial frame (start bit, 8 data bits, parity
//             bit), checks parity and presents the byte through a
//             valid/ready holding register. A frame that completes while the
//             holding register is still occupied is dropped and flagged with a
//             one-cycle overrun pulse.
//  Params   : ODD_PARITY - 0 even parity, 1 odd parity
//             LSB_FIRST  - 1 data bit 0 arrives first, 0 bit 7 arrives first
//  Ports    : clk        - sole clock, rising edge
//             rst_n      - synchronous active-low reset
//             rx_valid   - qualifies rx_bit (one line bit per strobe)
//             rx_bit     - serial line value, idle level 1
//             out_ready  - downstream accepts the held frame
//             out_valid  - held frame available
//             out_data   - received data byte
//             out_perr   - parity error flag for out_data
//             busy       - receiver is mid-frame
//             overrun    - one-cycle pulse when a completed frame is dropped
//             err_cnt    - saturating parity-error count (optional)
//  Option   : define SPRX_ERR_CNT_EN to add the err_cnt output.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_parity_rx #(
  parameter int ODD_PARITY = 0,
  parameter int LSB_FIRST  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic       rx_bit,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_perr,
  output logic       busy,
`ifdef SPRX_ERR_CNT_EN
  output logic       overrun,
  output logic [7:0] err_cnt
`else
  output logic       overrun
`endif
);

  localparam logic c_odd = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_perr_q, out_perr_d;
  logic       overrun_q, overrun_d;

  logic       par_cap;   // parity bit strobed this cycle
  logic       perr_w;
  logic       load_w;
  logic       drop_w;

  // Receive FSM: advances only on strobed cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_cap = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && !rx_bit) begin
          state_d = S_DATA;
          cnt_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (LSB_FIRST != 0) shreg_d = {rx_bit, shreg_q[7:1]};
          else                shreg_d = {shreg_q[6:0], rx_bit};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (rx_valid) begin
          par_cap = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Parity over the completed byte plus the incoming parity bit.
  assign perr_w = (^{shreg_q, rx_bit}) ^ c_odd;

  // A frame loads if the holder is empty or is being emptied this cycle.
  assign load_w = par_cap && (!out_valid_q || out_ready);
  assign drop_w = par_cap && out_valid_q && !out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_perr_d  = out_perr_q;
    overrun_d   = drop_w;
    if (load_w) begin
      out_valid_d = 1'b1;
      out_data_d  = shreg_q;
      out_perr_d  = perr_w;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      shreg_q     <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_perr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_perr_q  <= out_perr_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SPRX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts only frames that actually load; saturates at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (load_w && perr_w && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= 8'h00;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_perr  = out_perr_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_parity_rx
//  Purpose  : Self-checking bench for serial_parity_rx. Three instances share
//             one stimulus stream: even/LSB-first, odd/LSB-first and
//             even/MSB-first. Expected frames are queued as they are sent and
//             compared when the held frame is handed off.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_parity_rx;

  logic clk = 1'b0;
  logic rst_n, rx_valid, rx_bit, out_ready;

  logic       e_valid, o_valid, m_valid;
  logic [7:0] e_data, o_data, m_data;
  logic       e_perr, o_perr, m_perr;
  logic       e_busy, o_busy, m_busy;
  logic       e_ovr, o_ovr, m_ovr;
`ifdef SPRX_ERR_CNT_EN
  logic [7:0] e_ecnt, o_ecnt, m_ecnt;
`endif

  always #5 clk = ~clk;

  serial_parity_rx #(.ODD_PARITY(0), .LSB_FIRST(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .out_ready(out_ready), .out_valid(e_valid), .out_data(e_data),
    .out_perr(e_perr), .busy(e_busy),
`ifdef SPRX_ERR_CNT_EN
    .err_cnt(e_ecnt),
`endif
    .overrun(e_ovr));

  serial_parity_rx #(.ODD_PARITY(1), .LSB_FIRST(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .out_ready(out_ready), .out_valid(o_valid), .out_data(o_data),
    .out_perr(o_perr), .busy(o_busy),
`ifdef SPRX_ERR_CNT_EN
    .err_cnt(o_ecnt),
`endif
    .overrun(o_ovr));

  serial_parity_rx #(.ODD_PARITY(0), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .out_ready(out_ready), .out_valid(m_valid), .out_data(m_data),
    .out_perr(m_perr), .busy(m_busy),
`ifdef SPRX_ERR_CNT_EN
    .err_cnt(m_ecnt),
`endif
    .overrun(m_ovr));

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       perr_e;   // expected flag, even parity
    logic       perr_o;   // expected flag, odd parity
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr_e;
    logic       perr_o;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ovr_cnt  = 0;
  int   perr_dl  = 0;

  function automatic logic [7:0] brev(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: compare on each handoff seen by all three instances.
  always @(negedge clk) begin
    if (rst_n && e_ovr) ovr_cnt++;
    if (rst_n && (e_valid || o_valid || m_valid) && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_frame: actual data=0x%0h required none", e_data);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if (x.perr_e) perr_dl++;
        if (!(e_valid && o_valid && m_valid)) begin
          failures++;
          $display("FAIL valid_agree: actual e/o/m=%b%b%b required 111", e_valid, o_valid, m_valid);
        end
        check("even_data", {24'd0, e_data}, {24'd0, x.data});
        check("even_perr", {31'd0, e_perr}, {31'd0, x.perr_e});
        check("odd_data",  {24'd0, o_data}, {24'd0, x.data});
        check("odd_perr",  {31'd0, o_perr}, {31'd0, x.perr_o});
        check("msb_data",  {24'd0, m_data}, {24'd0, brev(x.data)});
        check("msb_perr",  {31'd0, m_perr}, {31'd0, x.perr_e});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    rx_valid = 1'b1;
    rx_bit   = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_bit   = 1'b1;
  endtask

  // Start bit, data LSB first on the line, then parity; random idle gaps.
  task automatic send_frame(input logic [7:0] d, input logic p, input bit lat_chk);
    strobe(1'b0);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 1));
      strobe(d[i]);
    end
    idle($urandom_range(0, 1));
    if (lat_chk) check("valid_before_parity", {31'd0, e_valid}, 32'd0);
    strobe(p);
    if (lat_chk) check("valid_latency", {31'd0, e_valid}, 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{8'h7F, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; rx_valid = 1'b0; rx_bit = 1'b1; out_ready = 1'b1;
    idle(2);
    check("rst_valid", {31'd0, e_valid}, 32'd0);
    check("rst_data",  {24'd0, e_data},  32'd0);
    check("rst_perr",  {31'd0, e_perr},  32'd0);
    check("rst_busy",  {31'd0, e_busy},  32'd0);
    check("rst_ovr",   {31'd0, e_ovr},   32'd0);
    rst_n = 1'b1;
    idle(1);

    // Table-driven frames with the consumer always ready.
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back('{vecs[i].data, vecs[i].perr_e, vecs[i].perr_o});
      send_frame(vecs[i].data, vecs[i].par, 1'b1);
      idle(2);
    end

    // Held frame with consumer stalled: second frame dropped.
    out_ready = 1'b0;
    exp_q.push_back('{8'h3C, 1'b0, 1'b1});
    send_frame(8'h3C, 1'b0, 1'b0);
    check("ovr_first", {31'd0, e_ovr}, 32'd0);
    idle(2);
    send_frame(8'hC3, 1'b0, 1'b0);
    check("ovr_pulse", {31'd0, e_ovr}, 32'd1);
    check("held_data", {24'd0, e_data}, 32'h3C);
    idle(1);
    check("ovr_one_cycle", {31'd0, e_ovr}, 32'd0);
    check("held_valid", {31'd0, e_valid}, 32'd1);
    idle(3);
    check("held_stable", {24'd0, e_data}, 32'h3C);
    out_ready = 1'b1;
    idle(1);
    check("valid_cleared", {31'd0, e_valid}, 32'd0);
    check("overrun_total", ovr_cnt, 32'd1);

`ifdef SPRX_ERR_CNT_EN
    check("err_cnt", {24'd0, e_ecnt}, perr_dl);
`endif

    // Reset mid-frame (with a start strobe competing) discards the partial frame.
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    check("busy_mid", {31'd0, e_busy}, 32'd1);
    rst_n = 1'b0; rx_valid = 1'b1; rx_bit = 1'b0;
    idle(1);
    rx_valid = 1'b0; rx_bit = 1'b1; rst_n = 1'b1;
    check("rst_mid_busy",  {31'd0, e_busy},  32'd0);
    check("rst_mid_valid", {31'd0, e_valid}, 32'd0);
    check("rst_mid_ovr",   {31'd0, e_ovr},   32'd0);
    exp_q.push_back('{8'h5A, 1'b0, 1'b1});
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(2);

    // Idle-level strobes never start a frame.
    for (int i = 0; i < 4; i++) strobe(1'b1);
    check("idle_busy", {31'd0, e_busy}, 32'd0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("overrun_final", ovr_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
